// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared data-memory defines and requester-id encoding
package dmem_arbiter_pkg;

  // Default data-memory geometry of the CPU
  localparam int DMEM_AW = 8;
  localparam int DMEM_DW = 16;

  // Which requester owns the memory port in the current cycle
  typedef enum logic [1:0] {
    REQ_NONE = 2'b00,
    REQ_CPU  = 2'b01,
    REQ_VGA  = 2'b10
  } req_id_t;

  // Width of a counter that must hold 0..max_val, never narrower than one bit
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dmem_arb_fair.sv
// rtl/dmem_arb_fair.sv - CPU-priority grant decision with bounded VGA wait
module dmem_arb_fair
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic cpu_req,
  input  logic vga_req,
  output logic cpu_gnt,
  output logic vga_gnt
);

  localparam int WW = cnt_width(MAX_WAIT);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  logic [WW-1:0] wait_cnt;
  req_id_t       winner;

  // VGA wins when alone or once it has been denied MAX_WAIT cycles in a row
  always_comb begin
    winner = REQ_NONE;
    if (reset) begin
      if (vga_req && (!cpu_req || (wait_cnt == WAIT_MAX))) begin
        winner = REQ_VGA;
      end else if (cpu_req) begin
        winner = REQ_CPU;
      end
    end
    cpu_gnt = (winner == REQ_CPU);
    vga_gnt = (winner == REQ_VGA);
  end

  // Count consecutive VGA denials; any grant or dropped request starts over
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (!vga_req || vga_gnt) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_MAX) begin
      wait_cnt <= wait_cnt + WW'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the data memory between CPU MEM stage and VGA scanner
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW       = DMEM_AW,
  parameter int DW       = DMEM_DW,
  parameter int MAX_WAIT = 2,
  parameter int CW       = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  input  logic          vga_req,
  input  logic [AW-1:0] vga_addr,
  output logic          vga_gnt,
  output logic [DW-1:0] vga_rdata,
  output logic          vga_rvalid,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [CW-1:0] stall_cnt
);

  req_id_t       owner;
  logic [AW-1:0] last_addr;

  dmem_arb_fair #(
    .MAX_WAIT(MAX_WAIT)
  ) u_fair (
    .clk    (clk),
    .reset  (reset),
    .cpu_req(cpu_req),
    .vga_req(vga_req),
    .cpu_gnt(cpu_gnt),
    .vga_gnt(vga_gnt)
  );

  // Steer the memory port to the granted requester; idle cycles hold the address and never write
  always_comb begin
    owner     = cpu_gnt ? REQ_CPU : (vga_gnt ? REQ_VGA : REQ_NONE);
    mem_addr  = last_addr;
    mem_we    = 1'b0;
    mem_wdata = cpu_wdata;
    case (owner)
      REQ_CPU: begin
        mem_addr = cpu_addr;
        mem_we   = cpu_we;
      end
      REQ_VGA: mem_addr = vga_addr;
      default: mem_addr = last_addr;
    endcase
  end

  assign cpu_stall = reset && cpu_req && !cpu_gnt;
  assign cpu_rdata = mem_rdata;
  assign vga_rdata = mem_rdata;

  // Remember the last driven address and who owns the read data returning next cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_addr  <= '0;
      cpu_rvalid <= 1'b0;
      vga_rvalid <= 1'b0;
    end else begin
      last_addr  <= mem_addr;
      cpu_rvalid <= cpu_gnt && !cpu_we;
      vga_rvalid <= vga_gnt;
    end
  end

  // Saturating count of pipeline-stall cycles
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (cpu_stall && (stall_cnt != {CW{1'b1}})) begin
      stall_cnt <= stall_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with a behavioural reference
module tb_dmem_arbiter;

  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int MW  = 2;
  localparam int CW  = 4;
  localparam int CNT_SAT  = (1 << CW) - 1;
  localparam int ZCNT_SAT = 65535;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, cpu_req, cpu_we, vga_req;
  logic [AW-1:0] cpu_addr, vga_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt, cpu_stall, cpu_rvalid, vga_gnt, vga_rvalid, mem_we;
  logic [DW-1:0] cpu_rdata, vga_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] stall_cnt;

  logic          z_cpu_gnt, z_cpu_stall, z_cpu_rvalid, z_vga_gnt, z_vga_rvalid, z_mem_we;
  logic [DW-1:0] z_cpu_rdata, z_vga_rdata, z_mem_wdata;
  logic [AW-1:0] z_mem_addr;
  logic [15:0]   z_stall_cnt;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MW), .CW(CW)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt), .vga_rdata(vga_rdata),
    .vga_rvalid(vga_rvalid), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
  );

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(0), .CW(16)) u_dut0 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(z_cpu_gnt), .cpu_stall(z_cpu_stall), .cpu_rdata(z_cpu_rdata), .cpu_rvalid(z_cpu_rvalid),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(z_vga_gnt), .vga_rdata(z_vga_rdata),
    .vga_rvalid(z_vga_rvalid), .mem_addr(z_mem_addr), .mem_we(z_mem_we), .mem_wdata(z_mem_wdata),
    .mem_rdata(mem_rdata), .stall_cnt(z_stall_cnt)
  );

  function automatic logic [DW-1:0] init_val(input int a);
    return DW'(a * 16'h1357) ^ 16'hA5C3;
  endfunction

  // Environment memory: single-port, one-cycle read latency, preloaded with init_val
  logic [DW-1:0] ram [256];
  bit            ram_wr [256];
  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr]    <= mem_wdata;
      ram_wr[mem_addr] <= 1'b1;
    end
    mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : init_val(int'(mem_addr));
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit            cg, vg, we, st, known, zc, zv;
    logic [CW-1:0] cnt;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [15:0]   zcnt;
  } exp_t;
  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rd_t;

  exp_t exp_q [$];
  rd_t  cpu_rq [$];
  rd_t  vga_rq [$];

  // Reference state: contents of memory, consecutive VGA denials, stall totals
  logic [DW-1:0] refm [256];
  int            run = 0, cnt = 0, zcnt = 0;
  bit            known = 0;
  logic [AW-1:0] last = '0;
  bit            m_cg, m_vg;

  int checks = 0, errors = 0;
  bit fin = 0, fin_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus and record what the specification says must happen
  task automatic drive(input bit rst, input bit creq, input bit cwe, input logic [AW-1:0] ca,
                       input logic [DW-1:0] cw, input bit vreq, input logic [AW-1:0] va);
    exp_t e;
    bit   vwin;
    reset = rst; cpu_req = creq; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cw;
    vga_req = vreq; vga_addr = va;
    vwin   = rst && vreq && (!creq || run >= MW);
    e.vg   = vwin;
    e.cg   = rst && creq && !vwin;
    e.we   = e.cg && cwe;
    e.st   = rst && creq && !e.cg;
    e.cnt  = CW'(cnt);
    e.zv   = rst && vreq;
    e.zc   = rst && creq && !vreq;
    e.zcnt = 16'(zcnt);
    e.wd   = cw;
    if (e.cg || e.vg) begin
      e.known = 1'b1;
      e.addr  = e.cg ? ca : va;
    end else begin
      e.known = known;
      e.addr  = last;
    end
    exp_q.push_back(e);
    m_cg = e.cg;
    m_vg = e.vg;
    if (!rst) begin
      run = 0; cnt = 0; zcnt = 0; known = 0;
    end else begin
      run = (vreq && !vwin) ? ((run < MW) ? run + 1 : MW) : 0;
      if (e.st && cnt < CNT_SAT) cnt++;
      if (creq && vreq && zcnt < ZCNT_SAT) zcnt++;
      if (e.cg || e.vg) begin
        known = 1'b1;
        last  = e.addr;
      end
      if (e.cg && !cwe) cpu_rq.push_back('{cyc + 1, refm[ca]});
      if (e.cg && cwe) refm[ca] = cw;
      if (e.vg) vga_rq.push_back('{cyc + 1, refm[va]});
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare each cycle's outputs and any returning read data against the scoreboard
  exp_t me;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      me = exp_q.pop_front();
      chk("cpu_gnt", cpu_gnt, me.cg);
      chk("vga_gnt", vga_gnt, me.vg);
      chk("mem_we", mem_we, me.we);
      chk("cpu_stall", cpu_stall, me.st);
      chk("stall_cnt", stall_cnt, me.cnt);
      if (me.known) chk("mem_addr", mem_addr, me.addr);
      if (me.we) chk("mem_wdata", mem_wdata, me.wd);
      chk("mw0_cpu_gnt", z_cpu_gnt, me.zc);
      chk("mw0_vga_gnt", z_vga_gnt, me.zv);
      chk("mw0_stall_cnt", z_stall_cnt, me.zcnt);
    end
    if (!reset) begin
      while (cpu_rq.size() > 0 && cpu_rq[0].due <= cyc) void'(cpu_rq.pop_front());
      while (vga_rq.size() > 0 && vga_rq[0].due <= cyc) void'(vga_rq.pop_front());
    end else begin
      if (cpu_rq.size() > 0 && cpu_rq[0].due == cyc) begin
        chk("cpu_rvalid", cpu_rvalid, 1);
        chk("cpu_rdata", cpu_rdata, cpu_rq[0].data);
        void'(cpu_rq.pop_front());
      end else begin
        chk("cpu_rvalid_idle", cpu_rvalid, 0);
      end
      if (vga_rq.size() > 0 && vga_rq[0].due == cyc) begin
        chk("vga_rvalid", vga_rvalid, 1);
        chk("vga_rdata", vga_rdata, vga_rq[0].data);
        void'(vga_rq.pop_front());
      end else begin
        chk("vga_rvalid_idle", vga_rvalid, 0);
      end
    end
    if (fin && !fin_done) begin
      chk("cpu_reads_outstanding", cpu_rq.size(), 0);
      chk("vga_reads_outstanding", vga_rq.size(), 0);
      chk("expectations_outstanding", exp_q.size(), 0);
      fin_done = 1'b1;
    end
  end

  // Stimulus: directed scenarios, then constrained-random traffic, then reset mid-read
  bit            rcreq, rcwe, rvreq, rrst;
  logic [AW-1:0] rca, rva;
  logic [DW-1:0] rcw;
  initial begin
    for (int i = 0; i < 256; i++) refm[i] = init_val(i);
    reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    vga_req = 1'b0; vga_addr = '0;
    @(posedge clk);
    #1;
    repeat (2) drive(0, 1, 1, 8'h40, 16'h5555, 1, 8'h41);
    drive(1, 1, 1, 8'h03, 16'hBEEF, 0, 8'h00);
    drive(1, 1, 0, 8'h03, 16'h0000, 0, 8'h00);
    drive(1, 0, 0, 8'h00, 16'h0000, 0, 8'h00);
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 8'h00, 16'h0000, 1, AW'(i));
    drive(1, 0, 0, 8'h00, 16'h0000, 0, 8'h00);
    repeat (6) drive(1, 1, 0, 8'h10, 16'h0000, 1, 8'h11);
    repeat (50) drive(1, 1, 1, 8'h20, 16'h1234, 1, 8'h21);
    rcreq = 0; rvreq = 0; rcwe = 0; rca = '0; rva = '0; rcw = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!(rcreq && !m_cg && $urandom_range(7) != 0)) begin
        rcreq = ($urandom_range(3) != 0);
        rcwe  = 1'($urandom_range(1));
        rca   = AW'($urandom_range(15));
        rcw   = DW'($urandom);
      end
      if (!(rvreq && !m_vg && $urandom_range(7) != 0)) begin
        rvreq = ($urandom_range(2) != 0);
        rva   = AW'($urandom_range(15));
      end
      rrst = ($urandom_range(199) != 0);
      drive(rrst, rcreq, rcwe, rca, rcw, rvreq, rva);
    end
    drive(1, 0, 0, 8'h00, 16'h0000, 0, 8'h00);
    drive(1, 1, 0, 8'h05, 16'h0000, 0, 8'h00);
    drive(0, 1, 1, 8'h06, 16'hDEAD, 1, 8'h07);
    drive(1, 0, 0, 8'h00, 16'h0000, 0, 8'h00);
    repeat (3) drive(1, 1, 0, 8'h06, 16'h0000, 1, 8'h08);
    repeat (2) drive(1, 0, 0, 8'h00, 16'h0000, 0, 8'h00);
    fin = 1'b1;
    repeat (2) @(posedge clk);
    if (!fin_done) $display("FAIL monitor_final_check actual=0 expected=1");
    $display("CHECKS %0d ERRORS %0d", checks, errors + (fin_done ? 0 : 1));
    $finish;
  end

endmodule
